// File: rtl/iomem_initiator.sv
// Single-outstanding iomem bus master: valid/ready command in, iomem transaction, response out.
// Optional REQ timeout abort is compiled in when IOMEM_INIT_TIMEOUT_EN is defined.
module iomem_initiator #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } state_t;

  state_t state, state_next;
  logic   cmd_accept;
  logic   bus_done;
  logic   timed_out;

  assign cmd_accept = (state == IDLE) && cmd_valid && cmd_ready;
  assign bus_done   = (state == REQ) && iomem_ready;

`ifdef IOMEM_INIT_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // Abort on the edge the count would reach TIMEOUT_CYCLES; a ready on that same edge wins.
  assign timed_out = (state == REQ) && !iomem_ready && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (state != REQ) begin
      wait_cnt <= '0;
    end else if (!iomem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end
`else
  assign timed_out = 1'b0;
`endif

  always_comb begin
    // NOTE: default assigned first so every path drives state_next and no latch is inferred.
    state_next = state;
    unique case (state)
      IDLE:    if (cmd_accept) state_next = REQ;
      REQ:     if (bus_done || timed_out) state_next = RSP;
      RSP:     if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // All outputs are registered so reset drives every one of them to 0, cmd_ready included.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      iomem_valid <= 1'b0;
      rsp_valid   <= 1'b0;
      iomem_addr  <= '0;
      iomem_wdata <= '0;
      iomem_wstrb <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
    end else begin
      state       <= state_next;
      cmd_ready   <= (state_next == IDLE);
      iomem_valid <= (state_next == REQ);
      rsp_valid   <= (state_next == RSP);

      if (cmd_accept) begin
        iomem_addr  <= cmd_addr;
        iomem_wdata <= cmd_wdata;
        iomem_wstrb <= cmd_write ? cmd_wstrb : 4'b0000;
      end

      if (bus_done) begin
        rsp_rdata <= iomem_rdata;
        rsp_err   <= 1'b0;
      end else if (timed_out) begin
        rsp_rdata <= ERR_RDATA;
        rsp_err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_iomem_initiator.sv
// Randomized self-checking bench for iomem_initiator with a 1-wait-state GPIO responder at 0x03xx_xxxx.
module tb_iomem_initiator;

  localparam int unsigned TO_CYC  = 4;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;
  localparam logic [31:0] GPIO    = 32'h0300_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        iomem_valid, iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr, iomem_wdata, iomem_rdata;

  logic        resp_ready = 1'b0;
  logic        spur       = 1'b0;
  logic        waited     = 1'b0;
  logic [31:0] gpio_reg   = 32'h0;
  int          ready_cnt  = 0;

  logic [31:0] model_gpio = 32'h0;
  int          tests = 0;
  int          fails = 0;

  assign iomem_ready = resp_ready | spur;

  iomem_initiator #(.TIMEOUT_CYCLES(TO_CYC), .ERR_RDATA(ERR_VAL)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata)
  );

  always #5 clk = ~clk;

  // GPIO responder: one wait state, then a single ready pulse carrying the post-write value.
  always @(negedge clk) begin
    if (reset || !iomem_valid || iomem_addr[31:24] != 8'h03) begin
      resp_ready = 1'b0;
      waited     = 1'b0;
    end else if (resp_ready) begin
      resp_ready = 1'b0;
      waited     = 1'b0;
    end else if (waited) begin
      for (int b = 0; b < 4; b++)
        if (iomem_wstrb[b]) gpio_reg[8*b +: 8] = iomem_wdata[8*b +: 8];
      iomem_rdata = gpio_reg;
      resp_ready  = 1'b1;
      ready_cnt++;
    end else begin
      waited = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] apply_write(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] mask;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~mask) | (d & mask);
  endfunction

  // Present a command at the current negedge; return at the negedge after the accept edge.
  task automatic send_cmd(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic ok);
    int n = 0;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
    while (!cmd_ready && n < 100) begin
      @(negedge clk); n++;
    end
    ok = cmd_ready;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom); cmd_addr = $urandom; cmd_wdata = $urandom; cmd_wstrb = 4'($urandom);
  endtask

  // Watch the bus until rsp_valid; checks the request is stable and drops before the response.
  task automatic wait_rsp(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int vcyc, output logic bus_ok, output logic to);
    int n = 0;
    vcyc = 0; bus_ok = 1'b1;
    while (!rsp_valid && n < 60) begin
      if (iomem_valid) begin
        vcyc++;
        if (iomem_addr !== a || iomem_wdata !== d || iomem_wstrb !== s) bus_ok = 1'b0;
      end
      @(negedge clk); n++;
    end
    to = !rsp_valid;
    if (iomem_valid) bus_ok = 1'b0;
  endtask

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic [3:0] s, input int hold, output logic [31:0] rd,
                        output logic er, output int vcyc, output logic bus_ok, output logic hung);
    logic ok, to;
    send_cmd(w, a, d, s, ok);
    wait_rsp(a, d, w ? s : 4'b0000, vcyc, bus_ok, to);
    hung = !ok || to;
    rd = rsp_rdata; er = rsp_err;
    repeat (hold) @(negedge clk);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    cmd_wstrb = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    tests++;
    if ({cmd_ready, rsp_valid, rsp_err, iomem_valid} !== 4'b0 ||
        {rsp_rdata, iomem_addr, iomem_wdata, iomem_wstrb} !== 100'b0) begin
      fails++;
      $display("FAIL reset_outputs: ctrl=%b rdata=%h addr=%h wdata=%h wstrb=%h, required all 0",
               {cmd_ready, rsp_valid, rsp_err, iomem_valid}, rsp_rdata, iomem_addr, iomem_wdata,
               iomem_wstrb);
    end
    reset = 1'b0;
    #1;
    tests++;
    if (cmd_ready !== 1'b0) begin
      fails++; $display("FAIL reset_release_ready: got %b required 0", cmd_ready);
    end
    @(negedge clk);
    tests++;
    if (cmd_ready !== 1'b1) begin
      fails++; $display("FAIL ready_after_reset: got %b required 1", cmd_ready);
    end
  endtask

  task automatic test_gpio_write();
    logic [31:0] rd; logic er, bus_ok, hung; int vcyc, rc0;
    rc0 = ready_cnt;
    do_txn(1'b1, GPIO, 32'h0000_00A5, 4'b0001, 0, rd, er, vcyc, bus_ok, hung);
    model_gpio = apply_write(model_gpio, 32'h0000_00A5, 4'b0001);
    tests++;
    if (hung || vcyc != 2 || !bus_ok || er !== 1'b0) begin
      fails++;
      $display("FAIL write_a5: hung=%b valid_cycles=%0d bus_ok=%b err=%b, required 0/2/1/0",
               hung, vcyc, bus_ok, er);
    end
    tests++;
    if (gpio_reg !== model_gpio || ready_cnt - rc0 != 1) begin
      fails++;
      $display("FAIL write_a5_gpio: gpio=%h readies=%0d, required %h/1", gpio_reg,
               ready_cnt - rc0, model_gpio);
    end
  endtask

  task automatic test_gpio_read();
    logic [31:0] rd; logic er, bus_ok, hung; int vcyc;
    do_txn(1'b0, GPIO, $urandom, 4'b1111, 1, rd, er, vcyc, bus_ok, hung);
    tests++;
    if (hung || vcyc != 2 || !bus_ok || er !== 1'b0 || rd !== 32'h0000_00A5) begin
      fails++;
      $display("FAIL read_a5: hung=%b valid_cycles=%0d bus_ok=%b err=%b rdata=%h, required 0/2/1/0/000000a5",
               hung, vcyc, bus_ok, er, rd);
    end
  endtask

  task automatic test_backpressure();
    logic ok, to, bus_ok, stable, blocked, hung; logic [31:0] d, rd; logic er; int vcyc;
    d = $urandom;
    send_cmd(1'b0, GPIO, d, 4'hF, ok);
    wait_rsp(GPIO, d, 4'b0000, vcyc, bus_ok, to);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO; cmd_wdata = 32'h0000_005A; cmd_wstrb = 4'b0001;
    stable = 1'b1; blocked = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_rdata !== model_gpio || rsp_err !== 1'b0) stable = 1'b0;
      if (cmd_ready !== 1'b0 || iomem_valid !== 1'b0) blocked = 1'b0;
    end
    tests++;
    if (!ok || to || !bus_ok || !stable) begin
      fails++;
      $display("FAIL rsp_hold_stable: ok=%b to=%b bus_ok=%b stable=%b rdata=%h, required 1/0/1/1/%h",
               ok, to, bus_ok, stable, rsp_rdata, model_gpio);
    end
    tests++;
    if (!blocked) begin
      fails++; $display("FAIL cmd_blocked_in_rsp: got accepted/bus activity, required blocked");
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      fails++;
      $display("FAIL rsp_handshake: rsp_valid=%b cmd_ready=%b, required 0/1", rsp_valid, cmd_ready);
    end
    send_cmd(1'b1, GPIO, 32'h0000_005A, 4'b0001, ok);
    wait_rsp(GPIO, 32'h0000_005A, 4'b0001, vcyc, bus_ok, to);
    hung = !ok || to; rd = rsp_rdata; er = rsp_err;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_gpio = apply_write(model_gpio, 32'h0000_005A, 4'b0001);
    tests++;
    if (hung || vcyc != 2 || !bus_ok || er !== 1'b0 || gpio_reg !== model_gpio) begin
      fails++;
      $display("FAIL queued_write: hung=%b valid_cycles=%0d bus_ok=%b err=%b gpio=%h rdata=%h, required 0/2/1/0/%h",
               hung, vcyc, bus_ok, er, gpio_reg, rd, model_gpio);
    end
  endtask

`ifdef IOMEM_INIT_TIMEOUT_EN
  task automatic test_timeout();
    logic ok, to, bus_ok, held; logic [31:0] d; int vcyc;
    d = $urandom;
    send_cmd(1'b0, 32'h0400_0000, d, 4'hF, ok);
    wait_rsp(32'h0400_0000, d, 4'b0000, vcyc, bus_ok, to);
    tests++;
    if (!ok || to || vcyc != int'(TO_CYC) || !bus_ok || rsp_rdata !== ERR_VAL || rsp_err !== 1'b1) begin
      fails++;
      $display("FAIL timeout: to=%b valid_cycles=%0d bus_ok=%b rdata=%h err=%b, required 0/%0d/1/%h/1",
               to, vcyc, bus_ok, rsp_rdata, rsp_err, TO_CYC, ERR_VAL);
    end
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    @(negedge clk);
    held = (rsp_valid === 1'b1 && rsp_rdata === ERR_VAL && rsp_err === 1'b1 && iomem_valid === 1'b0);
    tests++;
    if (!held) begin
      fails++;
      $display("FAIL late_ready: rsp_valid=%b rdata=%h err=%b iomem_valid=%b, required 1/%h/1/0",
               rsp_valid, rsp_rdata, rsp_err, iomem_valid, ERR_VAL);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask
`endif

  task automatic test_spurious_idle();
    logic quiet = 1'b1;
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (iomem_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b1) quiet = 1'b0;
    end
    tests++;
    if (!quiet) begin
      fails++;
      $display("FAIL spurious_idle: iomem_valid=%b rsp_valid=%b cmd_ready=%b, required 0/0/1",
               iomem_valid, rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic ok, bus_ok, hung, er; logic [31:0] rd; int vcyc;
    send_cmd(1'b0, GPIO, $urandom, 4'hF, ok);
    #1;
    reset = 1'b1;
    #1;
    tests++;
    if (!ok || iomem_valid !== 1'b0 || rsp_valid !== 1'b0 || cmd_ready !== 1'b0) begin
      fails++;
      $display("FAIL reset_in_req: ok=%b iomem_valid=%b rsp_valid=%b cmd_ready=%b, required 1/0/0/0",
               ok, iomem_valid, rsp_valid, cmd_ready);
    end
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    do_txn(1'b0, GPIO, $urandom, 4'hF, 0, rd, er, vcyc, bus_ok, hung);
    tests++;
    if (hung || vcyc != 2 || !bus_ok || er !== 1'b0 || rd !== model_gpio) begin
      fails++;
      $display("FAIL read_after_reset: hung=%b valid_cycles=%0d bus_ok=%b err=%b rdata=%h, required 0/2/1/0/%h",
               hung, vcyc, bus_ok, er, rd, model_gpio);
    end
  endtask

  task automatic test_random();
    logic w, er, bus_ok, hung, good; logic [31:0] a, d, rd; logic [3:0] s; int vcyc, rc0;
    rc0 = ready_cnt;
    for (int i = 0; i < 24; i++) begin
      w = 1'($urandom); a = {8'h03, 24'($urandom)}; d = $urandom; s = 4'($urandom);
      do_txn(w, a, d, s, $urandom_range(0, 3), rd, er, vcyc, bus_ok, hung);
      good = !hung && vcyc == 2 && bus_ok && er === 1'b0;
      if (w) model_gpio = apply_write(model_gpio, d, s);
      else if (rd !== model_gpio) good = 1'b0;
      tests++;
      if (!good) begin
        fails++;
        $display("FAIL random_txn[%0d]: w=%b addr=%h hung=%b valid_cycles=%0d bus_ok=%b err=%b rdata=%h, required 0/2/1/0 rdata=%h",
                 i, w, a, hung, vcyc, bus_ok, er, rd, model_gpio);
      end
    end
    tests++;
    if (ready_cnt - rc0 != 24 || gpio_reg !== model_gpio) begin
      fails++;
      $display("FAIL random_totals: readies=%0d gpio=%h, required 24/%h", ready_cnt - rc0,
               gpio_reg, model_gpio);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] items [4];
    int starts[$];
    int idx = 0, nrsp = 0, n = 0;
    logic pend = 1'b0, prev_v = 1'b0, order_ok = 1'b1, gap_ok = 1'b1;
    items = '{32'h01, 32'h02, 32'h04, 32'h08};
    rsp_ready = 1'b1;
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = GPIO; cmd_wdata = items[0]; cmd_wstrb = 4'b0001;
    while (nrsp < 4 && n < 100) begin
      if (pend) begin
        idx++; pend = 1'b0;
        if (idx < 4) cmd_wdata = items[idx];
        else cmd_valid = 1'b0;
      end
      if (iomem_valid && !prev_v) begin
        if (starts.size() >= 4 || iomem_wdata !== items[starts.size()] ||
            iomem_wstrb !== 4'b0001 || iomem_addr !== GPIO) order_ok = 1'b0;
        starts.push_back(n);
      end
      prev_v = iomem_valid;
      if (rsp_valid) begin
        nrsp++;
        if (rsp_err !== 1'b0) order_ok = 1'b0;
      end
      if (cmd_valid && cmd_ready) pend = 1'b1;
      @(negedge clk); n++;
    end
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) model_gpio = apply_write(model_gpio, items[i], 4'b0001);
    for (int i = 1; i < starts.size(); i++)
      if (starts[i] - starts[i-1] != 4) gap_ok = 1'b0;
    tests++;
    if (nrsp != 4 || starts.size() != 4 || !order_ok) begin
      fails++;
      $display("FAIL b2b_order: responses=%0d bursts=%0d order_ok=%b, required 4/4/1",
               nrsp, starts.size(), order_ok);
    end
    tests++;
    if (!gap_ok) begin
      fails++; $display("FAIL b2b_period: burst spacing not 4 cycles, required 4");
    end
    tests++;
    if (gpio_reg[7:0] !== 8'h08 || gpio_reg !== model_gpio) begin
      fails++; $display("FAIL b2b_gpio: got %h required %h", gpio_reg, model_gpio);
    end
  endtask

  initial begin
    test_reset();
    test_gpio_write();
    test_gpio_read();
    test_backpressure();
`ifdef IOMEM_INIT_TIMEOUT_EN
    test_timeout();
`endif
    test_spurious_idle();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
